// File: rtl/dec_pkg.sv
// dec_pkg: shared definitions for the dec_scan_n decoder family.
//   MODE_*  : encodings of the 2-bit mode input (11 is reserved and decodes as one-hot)
//   state_t : controller states IDLE / DIRECT / SCAN
package dec_pkg;

  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERM  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

endpackage

// File: rtl/dec_code_n.sv
// dec_code_n: combinational W-bit code to 2**W-bit decode.
//   code  in  W     code to decode
//   therm in  1     0: one-hot (y[i] = i==code), 1: thermometer (y[i] = i<=code)
//   y     out 2**W  decoded pattern
module dec_code_n #(
  parameter int W = 3
) (
  input  logic [W-1:0]    code,
  input  logic            therm,
  output logic [2**W-1:0] y
);

  localparam int N = 2**W;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    localparam logic [W-1:0] POS = W'(gi);
    assign y[gi] = therm ? (POS <= code) : (POS == code);
  end

endmodule

// File: rtl/dec_scan_n.sv
// dec_scan_n: registered W-to-2**W decoder with valid/ready input, one-hot / thermometer
// direct modes and an autonomous scan that shows every code for DWELL cycles.
//   clk       in   1     rising-edge clock
//   rst_n     in   1     asynchronous active-low reset
//   in_valid  in   1     request present
//   in_ready  out  1     request can be accepted (low while scanning)
//   x         in   W     code to decode / first code of a scan
//   mode      in   2     00 one-hot, 01 thermometer, 10 scan, 11 as 00
//   en        in   1     output enable; 0 masks y and freezes the scan
//   y         out  2**W  decoded output
//   y_valid   out  1     y holds a decoded value
//   scan_done out  1     one-cycle pulse when a scan completes
module dec_scan_n
  import dec_pkg::*;
#(
  parameter int W     = 3,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    x,
  input  logic [1:0]      mode,
  input  logic            en,
  output logic [2**W-1:0] y,
  output logic            y_valid,
  output logic            scan_done
);

  localparam int N  = 2**W;
  localparam int DW = $clog2(DWELL + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  if (W < 1 || DWELL < 1) begin : g_param_check
    $error("dec_scan_n: W and DWELL must both be >= 1");
  end

  state_t         state;
  logic [N-1:0]   y_reg;
  logic           y_valid_reg;
  logic           scan_done_reg;
  logic [W-1:0]   idx;
  logic [W-1:0]   last_idx;   // final code of the running scan: start code - 1, wrapped
  logic [DW-1:0]  dwell;

  logic           accept;
  logic           dwell_end;
  logic [W-1:0]   code_sel;
  logic           therm_sel;
  logic [N-1:0]   code_y;

  assign in_ready  = (state != SCAN);
  assign accept    = in_valid && in_ready;
  assign dwell_end = (dwell == DWELL_LAST);

  // One decoder serves both paths: an accepted request decodes x, otherwise
  // it looks ahead to the next scan code so the step can load it directly.
  always_comb begin
    code_sel  = accept ? x : idx + W'(1);
    therm_sel = accept && (mode == MODE_THERM);
  end

  dec_code_n #(.W(W)) u_code (
    .code  (code_sel),
    .therm (therm_sel),
    .y     (code_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      y_reg         <= '0;
      y_valid_reg   <= 1'b0;
      scan_done_reg <= 1'b0;
      idx           <= '0;
      last_idx      <= '0;
      dwell         <= '0;
    end else begin
      scan_done_reg <= 1'b0;
      if (accept) begin
        // Direct accepts load y even with en=0; only the output is masked.
        y_reg       <= code_y;
        y_valid_reg <= 1'b1;
        idx         <= x;
        dwell       <= '0;
        if (mode == MODE_SCAN) begin
          state    <= SCAN;
          last_idx <= x - W'(1);
        end else begin
          state <= DIRECT;
        end
      end else if (state == SCAN && en) begin
        if (dwell_end) begin
          dwell <= '0;
          if (idx == last_idx) begin
            // Scan complete: y keeps the last code and stays valid.
            scan_done_reg <= 1'b1;
            state         <= DIRECT;
          end else begin
            idx   <= code_sel;
            y_reg <= code_y;
          end
        end else begin
          dwell <= dwell + DW'(1);
        end
      end
    end
  end

  assign y         = en ? y_reg : '0;
  assign y_valid   = y_valid_reg;
  assign scan_done = scan_done_reg;

endmodule

// File: tb/tb_dec_scan_n.sv
// tb_dec_scan_n: scoreboard bench for dec_scan_n. One DUT at W=3/DWELL=4 and a
// second at W=1/DWELL=1; expected y values are queued when stimulus is driven
// and popped after the edge that should produce them.
module tb_dec_scan_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT, W=3, DWELL=4
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] x = '0;
  logic [1:0] mode = '0;
  logic       en = 1'b1;
  logic [7:0] y;
  logic       y_valid;
  logic       scan_done;

  // small DUT, W=1, DWELL=1
  logic       in_valid_s = 1'b0;
  logic       in_ready_s;
  logic [0:0] x_s = '0;
  logic [1:0] mode_s = '0;
  logic       en_s = 1'b1;
  logic [1:0] y_s;
  logic       y_valid_s;
  logic       scan_done_s;

  logic [7:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  dec_scan_n #(.W(3), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .mode(mode), .en(en), .y(y), .y_valid(y_valid), .scan_done(scan_done)
  );

  dec_scan_n #(.W(1), .DWELL(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .x(x_s), .mode(mode_s), .en(en_s), .y(y_s), .y_valid(y_valid_s), .scan_done(scan_done_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    vectors++;
    if (y !== 8'h00 || y_valid !== 1'b0 || in_ready !== 1'b1 || scan_done !== 1'b0) begin
      $display("FAIL reset_por: y=%h y_valid=%b in_ready=%b scan_done=%b, required 00 0 1 0",
               y, y_valid, in_ready, scan_done);
      miscompares++;
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    // start a scan, then pull reset mid-run
    in_valid = 1'b1; mode = 2'b10; x = 3'd2;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (y !== 8'h04 || in_ready !== 1'b0) begin
      $display("FAIL reset_scan_start: y=%h in_ready=%b, required 04 0", y, in_ready);
      miscompares++;
    end
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (y !== 8'h00 || y_valid !== 1'b0 || in_ready !== 1'b1 || scan_done !== 1'b0) begin
      $display("FAIL reset_async: y=%h y_valid=%b in_ready=%b scan_done=%b, required 00 0 1 0",
               y, y_valid, in_ready, scan_done);
      miscompares++;
    end
    tick();
    tick();
    vectors++;
    if (y !== 8'h00 || scan_done !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_hold: y=%h scan_done=%b in_ready=%b, required 00 0 1",
               y, scan_done, in_ready);
      miscompares++;
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    $display("reset: checked power-on and mid-scan reset");
  endtask

  task automatic test_onehot_sweep();
    logic [7:0] e;
    en = 1'b1; mode = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = 3'(i);
      exp_q.push_back(8'(16'h1 << i));
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (y !== e || y_valid !== 1'b1 || in_ready !== 1'b1) begin
        $display("FAIL onehot_x%0d: y=%h y_valid=%b in_ready=%b, required %h 1 1",
                 i, y, y_valid, in_ready, e);
        miscompares++;
      end
      $display("onehot x=%0d y=%h", i, y);
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (y !== 8'h80 || y_valid !== 1'b1) begin
      $display("FAIL onehot_hold: y=%h y_valid=%b, required 80 1", y, y_valid);
      miscompares++;
    end
  endtask

  task automatic test_thermometer();
    logic [1:0] modes[4];
    logic [2:0] xs[4];
    logic [7:0] e;
    modes = '{2'b01, 2'b01, 2'b01, 2'b11};
    xs    = '{3'd3, 3'd7, 3'd0, 3'd5};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; mode = modes[i]; x = xs[i];
      if (modes[i] == 2'b01) exp_q.push_back(8'((16'h2 << xs[i]) - 16'h1));
      else                   exp_q.push_back(8'(16'h1 << xs[i]));
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (y !== e || y_valid !== 1'b1) begin
        $display("FAIL therm_mode%b_x%0d: y=%h y_valid=%b, required %h 1",
                 modes[i], xs[i], y, y_valid, e);
        miscompares++;
      end
      $display("therm mode=%b x=%0d y=%h", modes[i], xs[i], y);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_scan_wrap();
    logic [7:0] e;
    en = 1'b1; in_valid = 1'b1; mode = 2'b10; x = 3'd6;
    for (int k = 0; k < 32; k++) exp_q.push_back(8'(16'h1 << ((6 + k / 4) % 8)));
    tick();
    // held request during the scan must be ignored
    mode = 2'b00; x = 3'd2;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick();
      e = exp_q.pop_front();
      vectors++;
      if (y !== e || in_ready !== 1'b0 || scan_done !== 1'b0) begin
        $display("FAIL scan_step%0d: y=%h in_ready=%b scan_done=%b, required %h 0 0",
                 k, y, in_ready, scan_done, e);
        miscompares++;
      end
    end
    tick();
    vectors++;
    if (y !== 8'h20 || scan_done !== 1'b1 || in_ready !== 1'b1 || y_valid !== 1'b1) begin
      $display("FAIL scan_done: y=%h scan_done=%b in_ready=%b y_valid=%b, required 20 1 1 1",
               y, scan_done, in_ready, y_valid);
      miscompares++;
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (y !== 8'h20 || scan_done !== 1'b0) begin
      $display("FAIL scan_after: y=%h scan_done=%b, required 20 0", y, scan_done);
      miscompares++;
    end
    $display("scan x=6 finished, y=%h", y);
  endtask

  task automatic test_enable();
    logic [7:0] e;
    logic       en_k;
    logic       done_exp;
    int         p;
    p = 0;
    en = 1'b1; in_valid = 1'b1; mode = 2'b10; x = 3'd0;
    exp_q.push_back(8'h01);
    tick();
    in_valid = 1'b0;
    e = exp_q.pop_front();
    vectors++;
    if (y !== e) begin
      $display("FAIL en_start: y=%h, required %h", y, e);
      miscompares++;
    end
    for (int k = 1; k <= 37; k++) begin
      en_k = !(k >= 10 && k <= 14);
      en = en_k;
      if (en_k) p++;
      exp_q.push_back(en_k ? 8'(16'h1 << ((p > 31 ? 31 : p) / 4)) : 8'h00);
      tick();
      e = exp_q.pop_front();
      done_exp = (k == 37);
      vectors++;
      if (y !== e || scan_done !== done_exp || in_ready !== done_exp) begin
        $display("FAIL en_step%0d: y=%h scan_done=%b in_ready=%b, required %h %b %b",
                 k, y, scan_done, in_ready, e, done_exp, done_exp);
        miscompares++;
      end
    end
    // direct accept with en=0 still loads the y register
    en = 1'b0; in_valid = 1'b1; mode = 2'b00; x = 3'd4;
    exp_q.push_back(8'h10);
    tick();
    in_valid = 1'b0;
    vectors++;
    if (y !== 8'h00) begin
      $display("FAIL en_mask_direct: y=%h, required 00", y);
      miscompares++;
    end
    en = 1'b1;
    #1;
    e = exp_q.pop_front();
    vectors++;
    if (y !== e) begin
      $display("FAIL en_resume_direct: y=%h, required %h", y, e);
      miscompares++;
    end
    $display("enable: scan with 5-cycle freeze finished, y=%h", y);
  endtask

  task automatic test_small_params();
    logic [7:0] e;
    in_valid_s = 1'b1; mode_s = 2'b10; x_s = 1'b1;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    tick();
    in_valid_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      e = exp_q.pop_front();
      vectors++;
      if (y_s !== e[1:0] || scan_done_s !== (k == 2) || in_ready_s !== (k == 2)) begin
        $display("FAIL small_step%0d: y=%b scan_done=%b in_ready=%b, required %b %b %b",
                 k, y_s, scan_done_s, in_ready_s, e[1:0], (k == 2), (k == 2));
        miscompares++;
      end
    end
    $display("small W=1 scan finished, y=%b", y_s);
  endtask

  initial begin
    test_reset();
    test_onehot_sweep();
    test_thermometer();
    test_scan_wrap();
    test_enable();
    test_small_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
